// File: rtl/touch_mt_poll_pkg.sv
// touch_pkg: shared types and constants for the multi-point touch poller.
// Contents: FSM state enum, point-record byte offsets and stride,
// default controller I2C/register addresses.
package touch_pkg;

    typedef enum logic [3:0] {
        RST_LO, RST_HI, IDLE, RD_STAT, W_STAT, RD_PTS, W_PTS, CLR, W_CLR, EMIT
    } state_t;

    localparam int F_ID       = 0;
    localparam int F_XL       = 1;
    localparam int F_XH       = 2;
    localparam int F_YL       = 3;
    localparam int F_YH       = 4;
    localparam int REC_BYTES  = 5;
    localparam int REC_STRIDE = 8;

    localparam logic [6:0]  DEF_SLAVE_ADDR = 7'h14;
    localparam logic [15:0] DEF_STAT_ADDR  = 16'h814E;
    localparam logic [15:0] DEF_PT_BASE    = 16'h8150;

endpackage

// File: rtl/touch_mt_poll_if.sv
// touch_mt_poll_if: byte-level I2C driver handshake bundle.
// master (poller): exec/rh_wl/addr/bit_ctrl/slave_addr/data_w/reg_num out;
//                  data_r/once_byte_done/done/ack in.
// slave (driver):  the mirror image.
interface touch_mt_poll_if;
    logic        i2c_exec;
    logic        i2c_rh_wl;
    logic        bit_ctrl;
    logic [15:0] i2c_addr;
    logic [6:0]  slave_addr;
    logic [7:0]  i2c_data_w;
    logic [7:0]  reg_num;
    logic [7:0]  i2c_data_r;
    logic        once_byte_done;
    logic        i2c_done;
    logic        i2c_ack;

    modport master (
        output i2c_exec, i2c_rh_wl, bit_ctrl, i2c_addr, slave_addr, i2c_data_w, reg_num,
        input  i2c_data_r, once_byte_done, i2c_done, i2c_ack
    );
    modport slave (
        input  i2c_exec, i2c_rh_wl, bit_ctrl, i2c_addr, slave_addr, i2c_data_w, reg_num,
        output i2c_data_r, once_byte_done, i2c_done, i2c_ack
    );
endinterface

// File: rtl/touch_mt_poll_rec_buf.sv
// touch_rec_buf: capture buffer for up to MAX_PTS touch records.
// Ports: clk, rst_n; byte write (we_i, rec_i, fld_i, data_i);
// indexed read (rd_idx_i -> id_o, x_o, y_o).
// Only the ID low nibble is kept since the track ID output is 4 bits.
module touch_rec_buf
    import touch_pkg::*;
#(
    parameter int MAX_PTS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [2:0]  rec_i,
    input  logic [2:0]  fld_i,
    input  logic [7:0]  data_i,
    input  logic [2:0]  rd_idx_i,
    output logic [3:0]  id_o,
    output logic [15:0] x_o,
    output logic [15:0] y_o
);
    // Per-record packing: [3:0] id, [19:4] x, [35:20] y (little-endian bytes).
    localparam int RW = 36;

    logic [MAX_PTS*RW-1:0] mem_q;
    logic [RW-1:0]         rec;
    int                    base;

    assign base = int'(rec_i) * RW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i && int'(rec_i) < MAX_PTS) begin
            if (int'(fld_i) == F_ID)
                mem_q[base +: 4] <= data_i[3:0];
            else if (int'(fld_i) < REC_BYTES)
                mem_q[base + 4 + (int'(fld_i) - 1) * 8 +: 8] <= data_i;
        end
    end

    assign rec  = int'(rd_idx_i) < MAX_PTS ? mem_q[int'(rd_idx_i) * RW +: RW] : '0;
    assign id_o = rec[3:0];
    assign x_o  = rec[19:4];
    assign y_o  = rec[35:20];

endmodule

// File: rtl/touch_mt_poll.sv
// touch_mt_poll: multi-point capacitive touch poller over a byte-level I2C driver.
// Ports: clk, rst_n (async active-low); panel reset/INT pins
// (touch_rst_n, touch_int_o, touch_int_oe, touch_int_i); i2c (driver handshake);
// point stream (pt_valid, pt_idx, pt_id, pt_x, pt_y); frame_done, touch_cnt, err.
module touch_mt_poll
    import touch_pkg::*;
#(
    parameter int          CLK_FREQ   = 1_000_000,
    parameter int          POLL_HZ    = 100,
    parameter int          INT_MODE   = 0,
    parameter int          MAX_PTS    = 5,
    parameter logic [6:0]  SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter logic [15:0] STAT_ADDR  = DEF_STAT_ADDR,
    parameter logic [15:0] PT_BASE    = DEF_PT_BASE,
    parameter int          SWAP_XY    = 0,
    parameter int          RST_CYC    = 10_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  touch_rst_n,
    output logic                  touch_int_o,
    output logic                  touch_int_oe,
    input  logic                  touch_int_i,
    touch_mt_poll_if.master       i2c,
    output logic                  pt_valid,
    output logic [2:0]            pt_idx,
    output logic [3:0]            pt_id,
    output logic [15:0]           pt_x,
    output logic [15:0]           pt_y,
    output logic                  frame_done,
    output logic [2:0]            touch_cnt,
    output logic                  err
);
    localparam logic [31:0] RST_LAST = 32'(RST_CYC - 1);
    localparam logic [31:0] POLL_LAST = 32'(CLK_FREQ / POLL_HZ - 1);

    state_t      state_q, state_d;
    logic [31:0] rcnt_q, rcnt_d, tmr_q;
    logic [2:0]  sync_q;
    logic [7:0]  stat_q, stat_d, stat_v;
    logic [2:0]  n_q, n_d, idx_q, idx_d, tcnt_q, tcnt_d;
    logic [5:0]  bc_q, bc_d, nbytes;
    logic        tick, trig, buf_we;
    logic [3:0]  id_b;
    logic [15:0] x_b, y_b;

    assign tick   = tmr_q == POLL_LAST;
    // sync_q[1] is the synchronised INT, sync_q[2] its previous value
    assign trig   = INT_MODE != 0 ? (sync_q[2] & ~sync_q[1]) : tick;
    assign nbytes = {n_q, 3'b000};
    // Status byte may arrive in the same cycle as i2c_done
    assign stat_v = i2c.once_byte_done ? i2c.i2c_data_r : stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q  <= '0;
            sync_q <= '1;
        end else begin
            tmr_q  <= tick ? '0 : tmr_q + 32'd1;
            sync_q <= {sync_q[1:0], touch_int_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_LO;
            rcnt_q  <= '0;
            stat_q  <= '0;
            n_q     <= '0;
            bc_q    <= '0;
            idx_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            stat_q  <= stat_d;
            n_q     <= n_d;
            bc_q    <= bc_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        stat_d     = stat_q;
        n_d        = n_q;
        bc_d       = bc_q;
        idx_d      = idx_q;
        tcnt_d     = tcnt_q;
        pt_valid   = 1'b0;
        frame_done = 1'b0;
        err        = 1'b0;
        buf_we     = 1'b0;
        case (state_q)
            RST_LO: begin
                rcnt_d  = rcnt_q == RST_LAST ? '0 : rcnt_q + 32'd1;
                state_d = rcnt_q == RST_LAST ? RST_HI : RST_LO;
            end
            RST_HI: begin
                rcnt_d  = rcnt_q == RST_LAST ? '0 : rcnt_q + 32'd1;
                state_d = rcnt_q == RST_LAST ? IDLE : RST_HI;
            end
            IDLE:    state_d = trig ? RD_STAT : IDLE;
            RD_STAT: state_d = W_STAT;
            W_STAT: begin
                if (i2c.once_byte_done) stat_d = i2c.i2c_data_r;
                if (i2c.i2c_done) begin
                    err     = i2c.i2c_ack;
                    n_d     = stat_v[3:0] > 4'(MAX_PTS) ? 3'(MAX_PTS) : stat_v[2:0];
                    state_d = (i2c.i2c_ack || !stat_v[7]) ? IDLE :
                              stat_v[3:0] == 4'd0 ? CLR : RD_PTS;
                end
            end
            RD_PTS: begin
                bc_d    = '0;
                state_d = W_PTS;
            end
            W_PTS: begin
                if (i2c.once_byte_done && bc_q < nbytes) begin
                    buf_we = 1'b1;
                    bc_d   = bc_q + 6'd1;
                end
                if (i2c.i2c_done) begin
                    err     = i2c.i2c_ack;
                    state_d = i2c.i2c_ack ? IDLE : CLR;
                end
            end
            CLR: state_d = W_CLR;
            W_CLR: begin
                if (i2c.i2c_done) begin
                    err     = i2c.i2c_ack;
                    tcnt_d  = i2c.i2c_ack ? tcnt_q : n_q;
                    idx_d   = '0;
                    state_d = i2c.i2c_ack ? IDLE : EMIT;
                end
            end
            EMIT: begin
                pt_valid   = idx_q < n_q;
                frame_done = !(idx_q < n_q);
                idx_d      = idx_q < n_q ? idx_q + 3'd1 : idx_q;
                state_d    = idx_q < n_q ? EMIT : IDLE;
            end
            default: state_d = RST_LO;
        endcase
    end

    touch_rec_buf #(.MAX_PTS(MAX_PTS)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (buf_we),
        .rec_i    (bc_q[5:3]),
        .fld_i    (bc_q[2:0]),
        .data_i   (i2c.i2c_data_r),
        .rd_idx_i (idx_q),
        .id_o     (id_b),
        .x_o      (x_b),
        .y_o      (y_b)
    );

    assign touch_rst_n    = state_q != RST_LO;
    assign touch_int_oe   = state_q inside {RST_LO, RST_HI};
    assign touch_int_o    = 1'b0;
    assign i2c.i2c_exec   = state_q inside {RD_STAT, RD_PTS, CLR};
    assign i2c.i2c_rh_wl  = !(state_q inside {CLR, W_CLR});
    assign i2c.i2c_addr   = state_q inside {RD_PTS, W_PTS} ? PT_BASE : STAT_ADDR;
    assign i2c.reg_num    = state_q inside {RD_PTS, W_PTS} ? {2'b00, nbytes} : 8'd1;
    assign i2c.i2c_data_w = 8'h00;
    assign i2c.bit_ctrl   = 1'b1;
    assign i2c.slave_addr = SLAVE_ADDR;
    assign touch_cnt      = tcnt_q;
    assign pt_idx         = pt_valid ? idx_q : '0;
    assign pt_id          = pt_valid ? id_b : '0;
    assign pt_x           = pt_valid ? (SWAP_XY != 0 ? y_b : x_b) : '0;
    assign pt_y           = pt_valid ? (SWAP_XY != 0 ? x_b : y_b) : '0;

endmodule

// File: tb/tb_touch_mt_poll.sv
// tb_touch_mt_poll: randomized self-checking bench for touch_mt_poll.
// u0 polls on a timer, u1 polls on INT edges with X/Y swapped; sel picks
// which instance the I2C responder and checks talk to.
module tb_touch_mt_poll;
    logic       clk = 1'b0, rst_n = 1'b0, int1 = 1'b1, sel = 1'b0;
    logic       once = 1'b0, done = 1'b0, ack = 1'b0;
    logic [7:0] data_r = 8'h00;

    always #5 clk = ~clk;

    touch_mt_poll_if if0 ();
    touch_mt_poll_if if1 ();

    assign if0.i2c_data_r     = data_r;
    assign if0.once_byte_done = once & ~sel;
    assign if0.i2c_done       = done & ~sel;
    assign if0.i2c_ack        = ack;
    assign if1.i2c_data_r     = data_r;
    assign if1.once_byte_done = once & sel;
    assign if1.i2c_done       = done & sel;
    assign if1.i2c_ack        = ack;

    logic        rn0, io0, oe0, pv0, fd0, er0, rn1, io1, oe1, pv1, fd1, er1;
    logic [2:0]  ix0, tc0, ix1, tc1;
    logic [3:0]  id0, id1;
    logic [15:0] x0, y0, x1, y1;

    touch_mt_poll #(.CLK_FREQ(1000), .POLL_HZ(5), .INT_MODE(0), .MAX_PTS(5), .SWAP_XY(0), .RST_CYC(4)) u0 (
        .clk(clk), .rst_n(rst_n), .touch_rst_n(rn0), .touch_int_o(io0), .touch_int_oe(oe0),
        .touch_int_i(1'b1), .i2c(if0), .pt_valid(pv0), .pt_idx(ix0), .pt_id(id0), .pt_x(x0),
        .pt_y(y0), .frame_done(fd0), .touch_cnt(tc0), .err(er0));

    touch_mt_poll #(.INT_MODE(1), .MAX_PTS(5), .SWAP_XY(1), .RST_CYC(4)) u1 (
        .clk(clk), .rst_n(rst_n), .touch_rst_n(rn1), .touch_int_o(io1), .touch_int_oe(oe1),
        .touch_int_i(int1), .i2c(if1), .pt_valid(pv1), .pt_idx(ix1), .pt_id(id1), .pt_x(x1),
        .pt_y(y1), .frame_done(fd1), .touch_cnt(tc1), .err(er1));

    logic        b_exec, b_rh, b_pv, b_fd, b_err, b_rn, b_oe, b_io;
    logic [15:0] b_addr, b_x, b_y;
    logic [7:0]  b_reg, b_dw;
    logic [2:0]  b_ix, b_tc;
    logic [3:0]  b_id;

    assign b_exec = sel ? if1.i2c_exec   : if0.i2c_exec;
    assign b_rh   = sel ? if1.i2c_rh_wl  : if0.i2c_rh_wl;
    assign b_addr = sel ? if1.i2c_addr   : if0.i2c_addr;
    assign b_reg  = sel ? if1.reg_num    : if0.reg_num;
    assign b_dw   = sel ? if1.i2c_data_w : if0.i2c_data_w;
    assign b_pv   = sel ? pv1 : pv0;
    assign b_fd   = sel ? fd1 : fd0;
    assign b_err  = sel ? er1 : er0;
    assign b_rn   = sel ? rn1 : rn0;
    assign b_oe   = sel ? oe1 : oe0;
    assign b_io   = sel ? io1 : io0;
    assign b_ix   = sel ? ix1 : ix0;
    assign b_tc   = sel ? tc1 : tc0;
    assign b_id   = sel ? id1 : id0;
    assign b_x    = sel ? x1 : x0;
    assign b_y    = sel ? y1 : y0;

    int checks = 0, fails = 0;
    int err_n = 0, fd_n = 0, ex_n = 0;
    int exp_tc = 0;
    logic [7:0]  rid[5];
    logic [15:0] rx[5], ry[5];
    logic [7:0]  rb[48];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (b_err) err_n++;
        if (b_fd) fd_n++;
        if (b_exec) ex_n++;
    end

    task automatic wait_exec(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = b_exec;
        end
        if (!ok) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic respond(input int nb, input logic a, input int stray, input bit wiggle, output logic es);
        for (int i = 0; i < nb + stray; i++) begin
            @(posedge clk); #1;
            data_r = i < nb ? rb[i] : 8'($urandom);
            once = 1'b1;
            if (wiggle && i == 2) int1 = 1'b1;
            if (wiggle && i == 6) int1 = 1'b0;
            @(posedge clk); #1;
            once = 1'b0;
        end
        @(posedge clk); #1;
        done = 1'b1;
        ack = a;
        @(negedge clk);
        es = b_err;
        @(posedge clk); #1;
        done = 1'b0;
        ack = 1'b0;
    endtask

    task automatic after_abort(input int e0, input int f0, input logic nk);
        repeat (3) @(negedge clk);
        check("abort_err_cnt", err_n - e0, nk);
        check("abort_fd_cnt", fd_n - f0, 0);
        check("abort_tcnt", b_tc, exp_tc);
    endtask

    task automatic run_frame(input logic [7:0] st, input logic ns, input logic np, input logic nc,
                             input int stray, input bit swap, input bit wiggle, input bit fixed);
        int n, e0, f0;
        bit ok;
        logic es;
        e0 = err_n;
        f0 = fd_n;
        wait_exec("stat", ok);
        if (!ok) return;
        check("stat_rh", b_rh, 1);
        check("stat_addr", b_addr, 16'h814E);
        check("stat_len", b_reg, 1);
        rb[0] = st;
        respond(1, ns, 0, 1'b0, es);
        check("stat_err", es, ns);
        if (ns || !st[7]) begin
            after_abort(e0, f0, ns);
            return;
        end
        n = st[3:0] > 4'd5 ? 5 : int'(st[3:0]);
        if (n > 0) begin
            for (int i = 0; i < n; i++) begin
                if (!fixed) begin
                    rid[i] = 8'($urandom);
                    rx[i] = 16'($urandom);
                    ry[i] = 16'($urandom);
                end
                rb[i*8]   = rid[i];
                rb[i*8+1] = rx[i][7:0];
                rb[i*8+2] = rx[i][15:8];
                rb[i*8+3] = ry[i][7:0];
                rb[i*8+4] = ry[i][15:8];
                for (int j = 5; j < 8; j++) rb[i*8+j] = 8'($urandom);
            end
            wait_exec("pts", ok);
            if (!ok) return;
            check("pts_rh", b_rh, 1);
            check("pts_addr", b_addr, 16'h8150);
            check("pts_len", b_reg, n * 8);
            respond(n * 8, np, stray, wiggle, es);
            check("pts_err", es, np);
            if (np) begin
                after_abort(e0, f0, 1'b1);
                return;
            end
        end
        wait_exec("clr", ok);
        if (!ok) return;
        check("clr_rh", b_rh, 0);
        check("clr_addr", b_addr, 16'h814E);
        check("clr_len", b_reg, 1);
        check("clr_data", b_dw, 0);
        respond(0, nc, 0, 1'b0, es);
        check("clr_err", es, nc);
        if (nc) begin
            after_abort(e0, f0, 1'b1);
            return;
        end
        exp_tc = n;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("pt_valid", b_pv, 1);
            check("pt_idx", b_ix, i);
            check("pt_id", b_id, rid[i][3:0]);
            check("pt_x", b_x, swap ? ry[i] : rx[i]);
            check("pt_y", b_y, swap ? rx[i] : ry[i]);
        end
        @(negedge clk);
        check("frame_done", b_fd, 1);
        check("fd_pv_low", b_pv, 0);
        check("touch_cnt", b_tc, n);
        @(negedge clk);
        check("fd_once", fd_n - f0, 1);
        check("no_err", err_n - e0, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int lo, oeh;
        bit ok;
        repeat (3) @(negedge clk);
        check("rst_touch_rst_n", b_rn, 0);
        check("rst_int_oe", b_oe, 1);
        check("rst_int_o", b_io, 0);
        check("rst_pt_valid", b_pv, 0);
        check("rst_frame_done", b_fd, 0);
        check("rst_err", b_err, 0);
        check("rst_exec", b_exec, 0);
        check("rst_touch_cnt", b_tc, 0);
        check("rst_pt_x", b_x, 0);
        check("rst_pt_y", b_y, 0);
        rst_n = 1'b1;
        lo = 0;
        oeh = 0;
        for (int i = 0; i < 12; i++) begin
            lo += int'(!b_rn);
            oeh += int'(b_oe);
            @(negedge clk);
        end
        check("rst_lo_cycles", lo, 4);
        check("int_drive_cycles", oeh, 8);
        check("idle_rst_n", b_rn, 1);
        check("idle_int_oe", b_oe, 0);

        rid[0] = 8'h00; rx[0] = 16'h0123; ry[0] = 16'h01E0;
        rid[1] = 8'h01; rx[1] = 16'h0300; ry[1] = 16'h0050;
        run_frame(8'h82, 0, 0, 0, 0, 0, 0, 1);
        run_frame(8'h00, 0, 0, 0, 0, 0, 0, 0);
        run_frame(8'h8F, 0, 0, 0, 2, 0, 0, 0);
        run_frame(8'h83, 1, 0, 0, 0, 0, 0, 0);
        run_frame(8'h83, 0, 0, 0, 0, 0, 0, 0);
        run_frame(8'h80, 0, 0, 0, 0, 0, 0, 0);
        run_frame(8'h82, 0, 1, 0, 0, 0, 0, 0);
        run_frame(8'h81, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++)
            run_frame({1'($urandom_range(0, 3) != 0), 3'b000, 4'($urandom)},
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 2), 0, 0, 0);

        wait_exec("mid", ok);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_touch_rst_n", b_rn, 0);
        check("mid_rst_int_oe", b_oe, 1);
        check("mid_rst_exec", b_exec, 0);
        check("mid_rst_touch_cnt", b_tc, 0);
        exp_tc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_idle_rst_n", b_rn, 1);
        check("mid_idle_oe", b_oe, 0);
        run_frame(8'h83, 0, 0, 0, 0, 0, 0, 0);

        sel = 1'b1;
        exp_tc = 0;
        repeat (3) @(negedge clk);
        int1 = 1'b0;
        rid[0] = 8'h07; rx[0] = 16'd10; ry[0] = 16'd20;
        run_frame(8'h81, 0, 0, 0, 0, 1, 1, 1);
        int1 = 1'b1;
        ex_n = 0;
        repeat (60) @(negedge clk);
        check("edge_dropped", ex_n, 0);
        int1 = 1'b0;
        run_frame(8'h82, 0, 0, 0, 0, 1, 0, 0);
        int1 = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
